// File: rtl/sample_readback.sv
`timescale 1ns/1ps
// Read side of the capture sample RAM: streams a circular window of bytes,
// oldest first, to the host transmitter over a valid/ready byte interface.
module sample_readback #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3584,
  parameter int CNT_W  = 13
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [CNT_W-1:0]  COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [7:0]        RAM_DIN,
  input  logic [7:0]        RAM_DOUT,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              busy_q;
  logic              done_q;
  logic              ram_en_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;

  logic [ADDR_W-1:0] start_addr_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [CNT_W-1:0]  count_d;

  // Out-of-range start addresses restart at 0; counts saturate at one full buffer.
  assign start_addr_d = (START_ADDR > LAST_ADDR) ? '0 : START_ADDR;
  assign count_d      = (COUNT > DEPTH_CNT) ? DEPTH_CNT : COUNT;
  assign addr_inc_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

  // Outputs are registered, so RAM_EN/DONE are raised on entry to READ/FIN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      ram_en_q <= 1'b0;
      if (ABORT) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        tx_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (START) begin
              addr_q      <= start_addr_d;
              remaining_q <= count_d;
              busy_q      <= 1'b1;
              if (count_d == '0) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_READ;
                ram_en_q   <= 1'b1;
                ram_addr_q <= start_addr_d;
              end
            end
          end
          S_READ: state_q <= S_LOAD;
          S_LOAD: begin
            tx_data_q   <= RAM_DOUT;
            tx_valid_q  <= 1'b1;
            remaining_q <= remaining_q - CNT_W'(1);
            state_q     <= S_SEND;
          end
          S_SEND: begin
            if (TX_READY) begin
              tx_valid_q <= 1'b0;
              if (remaining_q == '0) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                addr_q     <= addr_inc_d;
                ram_addr_q <= addr_inc_d;
                ram_en_q   <= 1'b1;
                state_q    <= S_READ;
              end
            end
          end
          S_FIN: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = 1'b0;
  assign RAM_DIN  = 8'h00;
  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;

endmodule

// File: tb/tb_sample_readback.sv
`timescale 1ns/1ps
// Bench for sample_readback: RAM model, byte monitor, table of readback vectors,
// hand-written stall/abort/reset sequences and a random-ready soak.
module tb_sample_readback;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 3584;
  localparam int CNT_W  = 13;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic              TX_READY = 1'b0;
  logic [ADDR_W-1:0] START_ADDR = '0;
  logic [CNT_W-1:0]  COUNT = '0;
  logic              BUSY, DONE, RAM_EN, RAM_WE, TX_VALID;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [7:0]        RAM_DIN, TX_DATA;
  logic [7:0]        RAM_DOUT = 8'h00;

  logic [7:0] mem [DEPTH];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall = 0;

  // Monitor state
  byte unsigned got[$];
  int           en_addrs[$];
  int done_cnt, viol, first_en, first_valid, last_hs, done_cyc, start_cyc;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    int addr;
    int cnt;
    int exp_len;
    int exp_first;
    int exp_last;
  } vec_t;
  vec_t vecs[6];

  sample_readback #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .START_ADDR(START_ADDR), .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE),
    .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_DIN(RAM_DIN),
    .RAM_DOUT(RAM_DOUT), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RAM_EN && RAM_ADDR < DEPTH) RAM_DOUT <= mem[RAM_ADDR];
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (RAM_EN) begin
        en_addrs.push_back(int'(RAM_ADDR));
        if (first_en < 0) first_en = cyc;
      end
      if (TX_VALID && first_valid < 0) first_valid = cyc;
      if (TX_VALID && TX_READY) begin
        got.push_back(TX_DATA);
        last_hs = cyc;
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_valid && !prev_ready && !prev_abort && (!TX_VALID || TX_DATA != prev_data)) viol++;
      if (RAM_EN && TX_VALID) viol++;
      if (RAM_WE || RAM_DIN != 8'h00) viol++;
      prev_valid = TX_VALID;
      prev_ready = TX_READY;
      prev_abort = ABORT;
      prev_data  = TX_DATA;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Transmitter ready policy
  initial forever begin
    @(posedge CLK);
    #1;
    case (ready_mode)
      0: TX_READY = 1'b1;
      1: TX_READY = 1'($urandom_range(0, 1));
      3: TX_READY = (got.size() < 2);
      4: if (got.size() == 1 && TX_VALID && stall < 20) begin
           TX_READY = 1'b0;
           stall++;
         end else begin
           TX_READY = 1'b1;
         end
      default: TX_READY = 1'b0;
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic pulse_start(input int addr, input int cnt);
    got.delete();
    en_addrs.delete();
    done_cnt = 0; viol = 0; first_en = -1; first_valid = -1; last_hs = -1; done_cyc = -1;
    @(posedge CLK);
    #1;
    START_ADDR = ADDR_W'(addr);
    COUNT      = CNT_W'(cnt);
    START      = 1'b1;
    start_cyc  = cyc;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic run_xfer(input int addr, input int cnt, input string tag);
    int  a, n, mism_d, mism_a;
    bit  seen;
    pulse_start(addr, cnt);
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge CLK);
      #1;
      if (DONE) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    @(negedge CLK);
    #1;
    chk({tag, "_busy_after_done"}, BUSY, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    // Reference: oldest-first walk of the circular buffer
    a = (addr >= DEPTH) ? 0 : addr;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    mism_d = (got.size() == n) ? 0 : 1;
    mism_a = (en_addrs.size() == n) ? 0 : 1;
    for (int k = 0; k < n; k++) begin
      if (k < got.size() && got[k] != mem[(a + k) % DEPTH]) mism_d++;
      if (k < en_addrs.size() && en_addrs[k] != (a + k) % DEPTH) mism_a++;
    end
    chk({tag, "_data_mismatches"}, mism_d, 0);
    chk({tag, "_addr_mismatches"}, mism_a, 0);
    chk({tag, "_protocol_violations"}, viol, 0);
    if (n > 0) begin
      chk({tag, "_ram_en_latency"}, first_en - start_cyc, 1);
      chk({tag, "_valid_latency"}, first_valid - start_cyc, 3);
      chk({tag, "_done_after_last_hs"}, done_cyc - last_hs, 1);
    end else begin
      chk({tag, "_done_latency_empty"}, done_cyc - start_cyc, 1);
      chk({tag, "_no_valid_empty"}, first_valid, -1);
    end
  endtask

  task automatic wait_got(input int num, input string tag);
    bit ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge CLK);
      #1;
      if (got.size() == num && TX_VALID) ok = 1;
    end
    chk({tag, "_reached"}, ok, 1);
  endtask

  initial begin
    int en0;
    vecs[0] = '{10,   4,    4,    'h0A, 'h0D};
    vecs[1] = '{3582, 4,    4,    'hFE, 'h01};
    vecs[2] = '{0,    0,    0,    0,    0};
    vecs[3] = '{4000, 3,    3,    'h00, 'h02};
    vecs[4] = '{3583, 1,    1,    'hFF, 'hFF};
    vecs[5] = '{100,  5000, 3584, 'h64, 'h63};
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_ram_en", RAM_EN, 0);
    chk("reset_tx_valid", TX_VALID, 0);
    chk("reset_ram_addr", RAM_ADDR, 0);
    chk("reset_tx_data", TX_DATA, 0);
    RESET_N = 1'b1;

    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].addr, vecs[i].cnt, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_len", i), got.size(), vecs[i].exp_len);
      if (vecs[i].exp_len > 0 && got.size() > 0) begin
        chk($sformatf("vec%0d_first", i), got[0], vecs[i].exp_first);
        chk($sformatf("vec%0d_last", i), got[got.size()-1], vecs[i].exp_last);
      end
    end

    // Stall on byte 2 with a stray START while busy
    stall = 0;
    ready_mode = 4;
    fork
      run_xfer(200, 4, "stall");
      begin
        for (int c = 0; c < 2000 && stall < 1; c++) @(negedge CLK);
        #1;
        en0 = en_addrs.size();
        for (int c = 0; c < 2000 && stall < 10; c++) @(negedge CLK);
        @(posedge CLK);
        #1;
        START_ADDR = 12'd900; COUNT = 13'd2; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int c = 0; c < 2000 && stall < 20; c++) @(negedge CLK);
        #1;
        chk("stall_no_reads", en_addrs.size(), en0);
        chk("stall_valid_held", TX_VALID, 1);
        chk("stall_data_held", TX_DATA, mem[201]);
      end
    join
    repeat (4) @(negedge CLK);
    #1;
    chk("stray_start_ignored", BUSY, 0);

    // Abort while byte 3 of 8 is waiting for a handshake
    ready_mode = 3;
    pulse_start(500, 8);
    wait_got(2, "abort");
    @(posedge CLK);
    #1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    @(negedge CLK);
    #1;
    chk("abort_tx_valid", TX_VALID, 0);
    chk("abort_busy", BUSY, 0);
    repeat (5) @(negedge CLK);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_bytes", got.size(), 2);
    ready_mode = 0;
    run_xfer(700, 5, "after_abort");

    // ABORT and START together in IDLE
    @(posedge CLK);
    #1;
    START_ADDR = 12'd5; COUNT = 13'd3; START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; ABORT = 1'b0;
    en0 = en_addrs.size();
    repeat (4) @(negedge CLK);
    #1;
    chk("abort_start_busy", BUSY, 0);
    chk("abort_start_no_read", en_addrs.size() - en0, 0);

    // Asynchronous reset in the middle of a transfer
    pulse_start(0, 10);
    wait_got(2, "rst");
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_outputs", {BUSY, DONE, RAM_EN, TX_VALID, RAM_ADDR, TX_DATA}, 0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    en0 = en_addrs.size();
    repeat (4) @(negedge CLK);
    #1;
    chk("rst_idle_busy", BUSY, 0);
    chk("rst_idle_no_read", en_addrs.size() - en0, 0);
    run_xfer(3580, 6, "after_rst");

    // Random soak against the buffer model
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    ready_mode = 1;
    for (int r = 0; r < 1000; r++) begin
      int addr;
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3570, 4095))
                                         : int'($urandom_range(0, DEPTH - 1));
      run_xfer(addr, int'($urandom_range(0, 10)), $sformatf("soak%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
